serial_frame_rx: RTL
====================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit (legal range 4..1024).
REQ-002 SHALL have parameter DATA_W, default 8: data bits per frame (legal range 5..16).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port serial_tx, input, 1: serial line from the master end; idles high.
REQ-006 SHALL have port data_o, output, DATA_W: received word.
REQ-007 SHALL have port valid_o, output, 1: data_o holds an unconsumed word.
REQ-008 SHALL have port ready_i, input, 1: consumer accepts data_o.
REQ-009 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port frame_err_o, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port overrun_o, output, 1: one-cycle pulse when a completed word is dropped.
REQ-012 SHALL have port parity_err_o, output, 1: one-cycle pulse when parity fails.

Function
REQ-013 SHALL pass serial_tx through a 2-flop synchronizer; all sampling uses the synchronized line (rx_s).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-015 SHALL leave IDLE for START on an rx_s high-to-low transition.
REQ-016 SHALL, in START, wait CLKS_PER_BIT/2 cycles, then sample rx_s: low -> DATA; high -> IDLE (glitch rejected, no flags).
REQ-017 SHALL, in DATA, sample at mid-bit every CLKS_PER_BIT cycles, shifting DATA_W bits LSB first.
REQ-018 SHALL, after the last data bit, go to PARITY when SERIAL_RX_PARITY_EN is defined, else to STOP.
REQ-019 SHALL, in STOP, sample one bit period after the previous sample.
REQ-020 SHALL, on a high stop sample, go to IDLE and commit the word.
REQ-021 SHALL, on a low stop sample, pulse frame_err_o, discard the word and go to RECOVER.
REQ-022 SHALL stay in RECOVER until rx_s is high, then go to IDLE.
REQ-023 SHALL register data_o and valid_o on the cycle after the stop sample (commit latency 1 cycle).
REQ-024 SHALL hold valid_o and data_o stable until a cycle with valid_o && ready_i, then clear valid_o.
REQ-025 SHALL, when a commit coincides with valid_o && ready_i, load the new word and keep valid_o high.
REQ-026 SHALL, when a commit occurs with valid_o && !ready_i, pulse overrun_o, drop the new word and keep the old data_o.
REQ-027 SHALL never commit a word that had a frame or parity error; valid_o is unaffected by such frames.

Reset
REQ-028 SHALL, while rst_n is low, force: FSM=IDLE; counters 0; data_o=0; valid_o, busy_o, frame_err_o, overrun_o, parity_err_o =0; synchronizer flops =1.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial word.
REQ-030 SHALL, after release, begin a frame only on a fresh falling edge.

Configuration
REQ-031 SHALL, with SERIAL_RX_PARITY_EN defined, sample one even-parity bit in PARITY; on a mismatch, pulse parity_err_o at the stop sample and discard the word (the stop bit is still checked).
REQ-032 SHALL, without SERIAL_RX_PARITY_EN, omit the PARITY state and tie parity_err_o to 0.

Structure
REQ-033 SHALL place the FSM state enum and the default CLKS_PER_BIT/DATA_W constants in shared package serial_pkg.
REQ-034 SHALL implement the synchronizer as sub-module serial_sync (2-flop, reset value 1).

Verification (CLKS_PER_BIT=16, DATA_W=8)
REQ-035 SHALL cover: frame 0xA5 with stop=1, ready_i=1 -> valid_o for 1 cycle, data_o=0xA5, no error flags.
REQ-036 SHALL cover: 4-cycle low glitch on an idle line -> FSM returns to IDLE, valid_o and all flags stay 0.
REQ-037 SHALL cover: frame 0x3C with stop=0 -> frame_err_o pulse, valid_o stays 0, FSM stays in RECOVER until the line goes high.
REQ-038 SHALL cover: frames 0x11 then 0x22 with ready_i=0 -> overrun_o pulse, data_o=0x11; then ready_i=1 -> valid_o falls.
REQ-039 SHALL cover: rst_n pulsed low after 4 data bits -> all outputs 0; the next complete frame 0x5A is received correctly.
REQ-040 SHALL cover, with SERIAL_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err_o pulse, no valid_o; the same frame with parity bit 1 -> data_o=0x07.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared defaults and FSM state encoding for the serial frame receiver.
// The PARITY state exists only when SERIAL_RX_PARITY_EN is defined.
package serial_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        RECOVER = 3'd5
    } rx_state_t;

endpackage

// File: rtl/serial_sync.sv
// serial_sync: two-flop synchronizer for the asynchronous serial line.
// Both stages reset high so the receiver sees an idle line out of reset.
module serial_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops bring the line into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/stop serial frame receiver with a one-word
// valid/ready output holding register.
// Optional even-parity bit between data and stop: define SERIAL_RX_PARITY_EN.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_tx,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              parity_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         next_state;
    logic              rx_s;
    logic              rx_prev;
    logic [1:0]        sync_fill;
    logic              armed;
    logic              fall_edge;
    logic [CNT_W-1:0]  clk_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              sample;
    logic              commit_ok;
    logic              frame_err_set;
`ifdef SERIAL_RX_PARITY_EN
    logic              parity_bad;
    logic              parity_err_set;
`endif

    serial_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (serial_tx),
        .q     (rx_s)
    );

    // Edge detector; only armed once the synchronizer has flushed its reset
    // value and the real line has been seen high, so a line held low across
    // reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign fall_edge = armed && rx_prev && !rx_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fall_edge) next_state = START;
            START:   if (sample) next_state = rx_s ? IDLE : DATA;
            DATA: begin
                if (sample && (bit_cnt == DATA_LAST)) begin
`ifdef SERIAL_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY:  if (sample) next_state = STOP;
`endif
            STOP:    if (sample) next_state = rx_s ? IDLE : RECOVER;
            RECOVER: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: busy flag, mid-bit sample strobe and stop-bit outcomes
    always_comb begin
        busy_o = (state != IDLE);
        sample = 1'b0;
        case (state)
            START:   sample = (clk_cnt == HALF_LAST);
            DATA:    sample = (clk_cnt == BIT_LAST);
`ifdef SERIAL_RX_PARITY_EN
            PARITY:  sample = (clk_cnt == BIT_LAST);
`endif
            STOP:    sample = (clk_cnt == BIT_LAST);
            default: sample = 1'b0;
        endcase
        frame_err_set = (state == STOP) && sample && !rx_s;
`ifdef SERIAL_RX_PARITY_EN
        commit_ok      = (state == STOP) && sample && rx_s && !parity_bad;
        parity_err_set = (state == STOP) && sample && parity_bad;
`else
        commit_ok      = (state == STOP) && sample && rx_s;
`endif
    end

    // Bit timing counter, data bit counter, shift register and parity check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
`ifdef SERIAL_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) || (state == RECOVER) || sample) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if ((state == DATA) && sample) begin
                shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end else if (state != DATA) begin
                bit_cnt <= '0;
            end

`ifdef SERIAL_RX_PARITY_EN
            if (state == IDLE) begin
                parity_bad <= 1'b0;
            end else if ((state == PARITY) && sample) begin
                parity_bad <= ^{shift_reg, rx_s};
            end
`endif
        end
    end

    // Output holding register with overrun detection and one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o  <= frame_err_set;
            overrun_o    <= commit_ok && valid_o && !ready_i;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_o <= parity_err_set;
`endif
            if (commit_ok) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_reg;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifndef SERIAL_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

endmodule
